usb_bit_decode: RTL and testbench
=================================

// Module: usb_bit_decode
// PURPOSE
//  Receive-side counterpart of the USB bit encoder. Takes the line level sampled once per bit
//  by the clock-recovery logic and NRZI-decodes it (J=1). Locates the SYNC field, removes
//  stuffed bits and assembles LSB-first bytes for the packet decoder.
//  Flags the packet boundaries (SOP/EOP), bit-stuff violations and misaligned EOP.
// PARAMETERS
//  SYNC_BITS  4  trailing decoded SYNC bits matched: (SYNC_BITS-1) zeros then a one; range 2..8
//  MAX_ONES   6  consecutive decoded ones after which one stuffed zero is mandatory
// PORTS
//  i_clk_48mhz  in   1  sole clock
//  i_rst        in   1  synchronous, active-high reset
//  i_dec_en     in   1  bit strobe; i_dec_bit and i_se0 are sampled only when it is high
//  i_dec_bit    in   1  sampled differential level, 1=J, 0=K; ignored when i_se0=1
//  i_se0        in   1  both lines low (SE0) at this strobe
//  o_byte       out  8  last assembled byte, LSB received first; holds its value between bytes
//  o_byte_valid out  1  1-cycle pulse, o_byte is new
//  o_sop        out  1  1-cycle pulse, SYNC detected
//  o_eop        out  1  1-cycle pulse, SE0 seen in an active packet
//  o_stuff_err  out  1  1-cycle pulse, bit-stuff violation
//  o_align_err  out  1  1-cycle pulse alongside o_eop when the EOP arrives mid-byte
//  o_active     out  1  high from the o_sop cycle through the o_eop cycle
// BEHAVIOUR
//  Reset: every output is 0, including o_byte. State IDLE, prev_level=1 (J), counters 0.
//  All outputs are registered. Every pulse asserts the cycle after the qualifying i_dec_en strobe.
//  Decode at each strobe with i_se0=0: dbit = (i_dec_bit == prev_level); then prev_level <= i_dec_bit.
//  SE0 strobes do not update prev_level. The IDLE/EOP->J exit sets prev_level=1.
//  A cycle with i_dec_en=0 changes no state (strobe gaps of any length are legal).
//  FSM:
//   IDLE: dbit shifts into an 8-bit history, entering at the MSB.
//     The SYNC_BITS-bit window at the MSB end matches (SYNC_BITS-1) zeros then a one -> DATA.
//     That transition pulses o_sop, clears bit_cntr and history, and sets ones_cntr=1
//     (the SYNC's final one counts toward stuffing).
//     An SE0 strobe in IDLE clears the history and stays in IDLE (no o_eop).
//   DATA, dbit strobe:
//     ones_cntr==MAX_ONES and dbit=0 -> stuffed bit, discarded, ones_cntr=0.
//     ones_cntr==MAX_ONES and dbit=1 -> o_stuff_err, go to ERR.
//     Otherwise shift dbit into the byte, bit_cntr++, and set ones_cntr to dbit ? ones_cntr+1 : 0.
//     The bit_cntr 7->0 wrap loads o_byte and pulses o_byte_valid.
//     A byte may complete immediately before its stuffed bit.
//     ones_cntr carries across byte boundaries.
//   DATA, SE0 strobe -> EOP: pulse o_eop; pulse o_align_err if bit_cntr!=0 (partial byte discarded).
//   ERR: no bytes are emitted; the first SE0 strobe -> EOP with o_eop, and o_align_err is never raised.
//   EOP: stays while SE0 persists; the first strobe with i_se0=0 -> IDLE, prev_level=1, o_active drops.
//  o_active falls on the cycle after the o_eop cycle.
//  i_rst mid-packet: the block returns to the reset state next cycle.
//  No o_eop is emitted and the partial byte is lost.
//  Widths: bit_cntr 3b wraps naturally; ones_cntr 3b saturates at MAX_ONES (never exceeds it).
// STRUCTURE
//  usb_pkg holds:
//   - the J level constant and state encoding (IDLE/DATA/ERR/EOP);
//   - the default SYNC_BITS and MAX_ONES values.
//  Sub-module usb_nrzi_unstuff: NRZI decode plus the ones_cntr stuff check.
//   Outputs per strobe: bit_valid, bit, stuff_err.
//   Inputs: clr (from the FSM) and preload_one.
//  The top level holds the FSM, the SYNC history and the byte assembler.
// TESTING (loop back through usb_bit_encode driven by 1-in-4 i_dec_en unless stated)
//  1. Idle J, SYNC, byte 0xA5, SE0, SE0, J.
//     Expect one o_sop, o_byte=0xA5 with a single o_byte_valid, one o_eop, and no errors.
//  2. SYNC, 0xFF, 0xFF, 0x00, EOP.
//     Stuffed zeros are removed: bytes 0xFF, 0xFF, 0x00 and no o_stuff_err.
//  3. Hand-built line: SYNC then seven unchanged levels.
//     Expect o_stuff_err once, no o_byte_valid until EOP, then o_eop with o_align_err=0.
//  4. SYNC, 0x3C plus 4 extra bits, then SE0.
//     Expect one byte 0x3C; o_eop and o_align_err in the same cycle.
//  5. i_rst asserted for 1 cycle after 3 data bits.
//     All outputs read 0 next cycle; the following packet 0x5A decodes correctly.
//  6. Random i_dec_en gaps of 1..7 cycles, and a SYNC with only 4 leading K/J bits.
//     Results must be identical to test 1.

Source files
------------

// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_pkg
//  Description : Shared constants and state encoding for the USB receive-side
//                bit decoder (NRZI decode, SYNC search, bit unstuffing).
//  Contents    : c_J_LEVEL        idle / J line level after NRZI mapping
//                c_SYNC_BITS_DEF  default number of trailing SYNC bits matched
//                c_MAX_ONES_DEF   default run of ones forcing a stuffed zero
//                state_t          decoder FSM encoding
//  Revision    : 1.0  initial release
// ============================================================================
package usb_pkg;

    localparam logic        c_J_LEVEL       = 1'b1;
    localparam int unsigned c_SYNC_BITS_DEF = 4;
    localparam int unsigned c_MAX_ONES_DEF  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // hunting for SYNC
        ST_DATA = 2'd1,   // assembling bytes
        ST_ERR  = 2'd2,   // stuff violation, waiting for SE0
        ST_EOP  = 2'd3    // SE0 in progress
    } state_t;

endpackage
`default_nettype wire

// File: rtl/usb_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
//  Module      : usb_nrzi_unstuff
//  Description : NRZI decoder plus bit-stuff checker. A decoded bit is 1 when
//                the line level did not change since the previous data strobe.
//                While checking is enabled, a zero following MAX_ONES ones is
//                swallowed as a stuffed bit and a one in that slot is flagged.
//  Ports       : i_clk, i_rst       clock, synchronous active-high reset
//                i_stb              data strobe (strobe without SE0)
//                i_line             sampled line level at the strobe
//                i_set_j            force previous level to J (end of EOP)
//                i_chk_en           stuff checking active
//                i_clr              clear the ones counter
//                i_preload_one      load the ones counter with 1
//                o_bit_valid        strobe carries a data bit (not stuffed)
//                o_bit              decoded bit value
//                o_stuff_err        one received where a stuffed zero belongs
//  Revision    : 1.0  initial release
// ============================================================================
module usb_nrzi_unstuff
    import usb_pkg::*;
#(
    parameter int unsigned MAX_ONES = c_MAX_ONES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stb,
    input  logic i_line,
    input  logic i_set_j,
    input  logic i_chk_en,
    input  logic i_clr,
    input  logic i_preload_one,
    output logic o_bit_valid,
    output logic o_bit,
    output logic o_stuff_err
);

    localparam logic [2:0] c_MAX = 3'(MAX_ONES);

    logic       prev_level_q, prev_level_d;
    logic [2:0] ones_cntr_q,  ones_cntr_d;
    logic       w_dbit;
    logic       w_at_limit;

    assign w_dbit     = (i_line == prev_level_q);
    assign w_at_limit = (ones_cntr_q == c_MAX);

    // Outputs depend only on the strobe and held state, never on the
    // counter controls, so the top level can derive i_clr/i_preload_one
    // from them without forming a combinational loop.
    assign o_bit       = w_dbit;
    assign o_bit_valid = i_stb & (~i_chk_en | ~w_at_limit);
    assign o_stuff_err = i_stb & i_chk_en & w_at_limit & w_dbit;

    always_comb begin
        prev_level_d = prev_level_q;
        ones_cntr_d  = ones_cntr_q;

        if (i_set_j) begin
            prev_level_d = c_J_LEVEL;
        end else if (i_stb) begin
            prev_level_d = i_line;
        end

        if (i_clr) begin
            ones_cntr_d = 3'd0;
        end else if (i_preload_one) begin
            ones_cntr_d = 3'd1;
        end else if (i_stb && i_chk_en) begin
            // At the limit the slot is either a stuffed zero or an error;
            // both restart the run, so the counter never passes MAX_ONES.
            if (w_at_limit) begin
                ones_cntr_d = 3'd0;
            end else begin
                ones_cntr_d = w_dbit ? (ones_cntr_q + 3'd1) : 3'd0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_level_q <= c_J_LEVEL;
            ones_cntr_q  <= 3'd0;
        end else begin
            prev_level_q <= prev_level_d;
            ones_cntr_q  <= ones_cntr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_bit_decode.sv
`default_nettype none
// ============================================================================
//  Module      : usb_bit_decode
//  Description : USB receive bit decoder. NRZI-decodes the per-bit line level,
//                finds SYNC, strips stuffed bits and assembles LSB-first bytes.
//                Flags SOP, EOP, stuff violations and EOP arriving mid-byte.
//                All outputs are registered; pulses appear the cycle after the
//                qualifying strobe.
//  Ports       : i_clk_48mhz   clock
//                i_rst         synchronous active-high reset
//                i_dec_en      bit strobe qualifying i_dec_bit / i_se0
//                i_dec_bit     line level, 1=J 0=K
//                i_se0         single-ended zero at this strobe
//                o_byte        last assembled byte (held between bytes)
//                o_byte_valid  pulse, o_byte updated
//                o_sop         pulse, SYNC found
//                o_eop         pulse, SE0 during an active packet
//                o_stuff_err   pulse, bit-stuff violation
//                o_align_err   pulse with o_eop when a byte was incomplete
//                o_active      high from the o_sop cycle through o_eop cycle
//  Revision    : 1.0  initial release
// ============================================================================
module usb_bit_decode
    import usb_pkg::*;
#(
    parameter int unsigned SYNC_BITS = c_SYNC_BITS_DEF,
    parameter int unsigned MAX_ONES  = c_MAX_ONES_DEF
) (
    input  logic       i_clk_48mhz,
    input  logic       i_rst,
    input  logic       i_dec_en,
    input  logic       i_dec_bit,
    input  logic       i_se0,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_sop,
    output logic       o_eop,
    output logic       o_stuff_err,
    output logic       o_align_err,
    output logic       o_active
);

    // Newest bit sits at the MSB, so the last SYNC_BITS bits in time order
    // read as one, then SYNC_BITS-1 zeros going down from bit 7.
    localparam logic [SYNC_BITS-1:0] c_SYNC_PAT = {1'b1, {(SYNC_BITS-1){1'b0}}};

    state_t     state_q, state_d;
    logic [7:0] hist_q, hist_d;
    logic [2:0] bit_cntr_q, bit_cntr_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_valid_q, byte_valid_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       serr_q, serr_d;
    logic       aerr_q, aerr_d;
    logic       active_q, active_d;

    logic       w_bit_stb, w_se0_stb;
    logic       w_bit_valid, w_bit, w_stuff_err;
    logic       w_sync_hit;
    logic [7:0] w_hist_shift;
    logic [7:0] w_byte_shift;
    logic       w_unused_hist_lsb;

    assign w_bit_stb    = i_dec_en & ~i_se0;
    assign w_se0_stb    = i_dec_en &  i_se0;
    assign w_hist_shift = {w_bit, hist_q[7:1]};
    assign w_byte_shift = {w_bit, shreg_q[7:1]};

    // The oldest history bit simply falls off the end of the shift.
    assign w_unused_hist_lsb = hist_q[0];

    assign w_sync_hit = (state_q == ST_IDLE) && w_bit_stb &&
                        (w_hist_shift[7 -: SYNC_BITS] == c_SYNC_PAT);

    usb_nrzi_unstuff #(
        .MAX_ONES (MAX_ONES)
    ) u_nrzi_unstuff (
        .i_clk         (i_clk_48mhz),
        .i_rst         (i_rst),
        .i_stb         (w_bit_stb),
        .i_line        (i_dec_bit),
        .i_set_j       ((state_q == ST_EOP) && w_bit_stb),
        .i_chk_en      (state_q == ST_DATA),
        .i_clr         ((state_q == ST_IDLE) && !w_sync_hit),
        .i_preload_one (w_sync_hit),   // the SYNC's final one starts the run
        .o_bit_valid   (w_bit_valid),
        .o_bit         (w_bit),
        .o_stuff_err   (w_stuff_err)
    );

    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        bit_cntr_d   = bit_cntr_q;
        shreg_d      = shreg_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        serr_d       = 1'b0;
        aerr_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A cleared history holds all ones: only decoded zeros can
                // build toward a SYNC match, so idle J never matches.
                if (w_se0_stb) begin
                    hist_d = '1;
                end else if (w_bit_valid) begin
                    if (w_sync_hit) begin
                        state_d    = ST_DATA;
                        sop_d      = 1'b1;
                        hist_d     = '1;
                        bit_cntr_d = 3'd0;
                    end else begin
                        hist_d = w_hist_shift;
                    end
                end
            end
            ST_DATA: begin
                if (w_se0_stb) begin
                    state_d    = ST_EOP;
                    eop_d      = 1'b1;
                    aerr_d     = (bit_cntr_q != 3'd0);
                    bit_cntr_d = 3'd0;
                end else if (w_stuff_err) begin
                    state_d = ST_ERR;
                    serr_d  = 1'b1;
                end else if (w_bit_valid) begin
                    shreg_d    = w_byte_shift;
                    bit_cntr_d = bit_cntr_q + 3'd1;
                    if (bit_cntr_q == 3'd7) begin
                        byte_d       = w_byte_shift;
                        byte_valid_d = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                if (w_se0_stb) begin
                    state_d    = ST_EOP;
                    eop_d      = 1'b1;
                    bit_cntr_d = 3'd0;
                end
            end
            ST_EOP: begin
                if (w_bit_stb) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Active covers the packet body and exactly the first EOP cycle.
        active_d = (state_d == ST_DATA) || (state_d == ST_ERR) ||
                   ((state_d == ST_EOP) && (state_q != ST_EOP));
    end

    always_ff @(posedge i_clk_48mhz) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            hist_q       <= '1;
            bit_cntr_q   <= 3'd0;
            shreg_q      <= 8'h00;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            serr_q       <= 1'b0;
            aerr_q       <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            bit_cntr_q   <= bit_cntr_d;
            shreg_q      <= shreg_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            serr_q       <= serr_d;
            aerr_q       <= aerr_d;
            active_q     <= active_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_sop        = sop_q;
    assign o_eop        = eop_q;
    assign o_stuff_err  = serr_q;
    assign o_align_err  = aerr_q;
    assign o_active     = active_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_bit_decode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_usb_bit_decode
//  Description : Self-checking bench for usb_bit_decode. A strobe-level vector
//                table covers a clean packet and a stuff violation; an NRZI
//                encoder model with bit stuffing drives the remaining packets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_usb_bit_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_en;
    logic       dec_bit;
    logic       se0;
    logic [7:0] byte_o;
    logic       bv, sop, eop, serr, aerr, act;

    always #5 clk = ~clk;

    usb_bit_decode #(
        .SYNC_BITS (4),
        .MAX_ONES  (6)
    ) dut (
        .i_clk_48mhz  (clk),
        .i_rst        (rst),
        .i_dec_en     (dec_en),
        .i_dec_bit    (dec_bit),
        .i_se0        (se0),
        .o_byte       (byte_o),
        .o_byte_valid (bv),
        .o_sop        (sop),
        .o_eop        (eop),
        .o_stuff_err  (serr),
        .o_align_err  (aerr),
        .o_active     (act)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- output monitor (sole writer of m_*) ----------------
    int         m_sop = 0, m_eop = 0, m_serr = 0, m_aerr = 0, m_orphan = 0;
    logic [7:0] m_bytes[$];

    always @(negedge clk) begin
        if (sop)  m_sop++;
        if (eop)  m_eop++;
        if (serr) m_serr++;
        if (aerr) m_aerr++;
        if (aerr && !eop) m_orphan++;
        if (bv)   m_bytes.push_back(byte_o);
    end

    int s_sop, s_eop, s_serr, s_aerr, s_orphan, s_nb;

    task automatic snap();
        s_sop = m_sop; s_eop = m_eop; s_serr = m_serr;
        s_aerr = m_aerr; s_orphan = m_orphan; s_nb = m_bytes.size();
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic strobe(input logic b, input logic s);
        dec_en = 1'b1; dec_bit = b; se0 = s;
        @(posedge clk); #1;
        dec_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [13:0] outs();
        return {sop, bv, byte_o, eop, serr, aerr, act};
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        b;
        logic        s;
        logic [13:0] exp;   // {sop, byte_valid, byte[7:0], eop, stuff_err, align_err, active}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic b, input logic s, input logic xsop, input logic xbv,
                       input logic [7:0] xby, input logic xeop, input logic xserr,
                       input logic xaerr, input logic xact);
        vec_t v;
        v.b = b; v.s = s;
        v.exp = {xsop, xbv, xby, xeop, xserr, xaerr, xact};
        tbl.push_back(v);
    endtask

    task automatic add_sync(input logic [7:0] held);
        for (int i = 0; i < 7; i++) add((i % 2 == 0) ? 1'b0 : 1'b1, 1'b0, 0, 0, held, 0, 0, 0, 0);
        add(1'b0, 1'b0, 1, 0, held, 0, 0, 0, 1);
    endtask

    // ---------------- encoder model ----------------
    logic       tx_level;
    int         tx_ones;
    logic [7:0] exp_q[$];

    task automatic tx_bit(input logic d, input bit rgap);
        tx_level = d ? tx_level : ~tx_level;
        strobe(tx_level, 1'b0);
        idle(rgap ? int'($urandom_range(7, 1)) : 3);
    endtask

    task automatic tx_data_bit(input logic d, input bit rgap);
        tx_bit(d, rgap);
        if (d) tx_ones++; else tx_ones = 0;
        if (tx_ones == 6) begin
            tx_bit(1'b0, rgap);
            tx_ones = 0;
        end
    endtask

    task automatic send_pkt(input int n_extra, input logic [7:0] extra,
                            input bit short_sync, input bit rgap, input bit do_eop);
        logic [7:0] cur;
        tx_level = 1'b1;
        for (int i = 0; i < 3; i++) tx_bit(1'b1, rgap);
        for (int i = 0; i < (short_sync ? 3 : 7); i++) tx_bit(1'b0, rgap);
        tx_bit(1'b1, rgap);
        tx_ones = 1;
        for (int k = 0; k < exp_q.size(); k++) begin
            cur = exp_q[k];
            for (int j = 0; j < 8; j++) tx_data_bit(cur[j], rgap);
        end
        for (int j = 0; j < n_extra; j++) tx_data_bit(extra[j], rgap);
        if (do_eop) begin
            strobe(1'b0, 1'b1); idle(3);
            strobe(1'b0, 1'b1); idle(3);
            tx_level = 1'b1;
            strobe(1'b1, 1'b0); idle(3);
            for (int i = 0; i < 2; i++) tx_bit(1'b1, rgap);
        end
    endtask

    task automatic check_pkt(input string nm, input int x_serr, input int x_aerr);
        check({nm, " sop count"}, m_sop - s_sop, 1);
        check({nm, " byte count"}, m_bytes.size() - s_nb, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (s_nb + k < m_bytes.size())
                check($sformatf("%s byte%0d", nm, k), {24'h0, m_bytes[s_nb + k]}, {24'h0, exp_q[k]});
        check({nm, " eop count"}, m_eop - s_eop, 1);
        check({nm, " stuff_err count"}, m_serr - s_serr, x_serr);
        check({nm, " align_err count"}, m_aerr - s_aerr, x_aerr);
        check({nm, " align_err w/o eop"}, m_orphan - s_orphan, 0);
        check({nm, " active after"}, {31'h0, act}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] lv_a5;

        rst = 1'b1; dec_en = 1'b0; dec_bit = 1'b1; se0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {18'h0, outs()}, 0);
        rst = 1'b0;
        idle(2);
        check("post-reset outputs", {18'h0, outs()}, 0);

        // ---- table: clean 0xA5 packet, then SYNC + seven unchanged levels ----
        lv_a5 = 8'b0011_0110;   // line levels for 0xA5 after a SYNC ending in K
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 0, 0, 8'h00, 0, 0, 0, 0);
        add_sync(8'h00);
        for (int i = 0; i < 7; i++) add(lv_a5[i], 1'b0, 0, 0, 8'h00, 0, 0, 0, 1);
        add(lv_a5[7], 1'b0, 0, 1, 8'hA5, 0, 0, 0, 1);
        add(1'b0, 1'b1, 0, 0, 8'hA5, 1, 0, 0, 1);
        add(1'b0, 1'b1, 0, 0, 8'hA5, 0, 0, 0, 0);
        add(1'b1, 1'b0, 0, 0, 8'hA5, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 0, 0, 8'hA5, 0, 0, 0, 0);
        add_sync(8'hA5);
        for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 0, 0, 8'hA5, 0, (i == 5), 0, 1);
        add(1'b0, 1'b1, 0, 0, 8'hA5, 1, 0, 0, 1);
        add(1'b0, 1'b1, 0, 0, 8'hA5, 0, 0, 0, 0);
        add(1'b1, 1'b0, 0, 0, 8'hA5, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            strobe(tbl[i].b, tbl[i].s);
            check($sformatf("vec%0d {sop,bv,byte,eop,serr,aerr,act}", i), {18'h0, outs()}, {18'h0, tbl[i].exp});
            idle(3);
        end

        // ---- stuffed zeros removed, including one right after a byte ----
        snap(); exp_q = '{8'hFF, 8'hFF, 8'h00};
        send_pkt(0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_pkt("stuff FF FF 00", 0, 0);

        snap(); exp_q = '{8'hFC, 8'h01};
        send_pkt(0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_pkt("stuff at byte end", 0, 0);

        // ---- partial byte before EOP ----
        snap(); exp_q = '{8'h3C};
        send_pkt(4, 8'h0D, 1'b0, 1'b0, 1'b1);
        check_pkt("misaligned eop", 0, 1);

        // ---- reset mid-packet ----
        snap(); exp_q = {};
        send_pkt(3, 8'h05, 1'b0, 1'b0, 1'b0);
        check("pre-reset sop count", m_sop - s_sop, 1);
        check("pre-reset active", {31'h0, act}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid-packet reset outputs", {18'h0, outs()}, 0);
        rst = 1'b0;
        idle(3);
        check("reset eop count", m_eop - s_eop, 0);
        check("reset byte count", m_bytes.size() - s_nb, 0);
        snap(); exp_q = '{8'h5A};
        send_pkt(0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_pkt("after reset 5A", 0, 0);

        // ---- random strobe gaps with a short SYNC ----
        snap(); exp_q = '{8'hA5};
        send_pkt(0, 8'h00, 1'b1, 1'b1, 1'b1);
        check_pkt("gaps short sync", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
